i2s_slave_rx: RTL and testbench

- I2S slave receiver: takes an externally driven bclk/lrclk pair and serial data, and deserializes stereo sample pairs.
- Delivers pairs to the system through a valid/ready handshake.
- Is the far-end counterpart of our I2S master codec: it sits on the sysclk domain, oversamples the I2S lines, and needs no generated clocks.

---
 rtl/i2s_slave_rx.sv | 198 +++++++++++++++++++
 tb/tb_i2s_slave_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_slave_rx.sv
// i2s_slave_rx: oversampling I2S slave receiver on the sysclk domain.
// The external bclk, lrclk and din are synchronized and the bclk rising edges are detected.
// Left/right words are deserialized MSB-first and delivered as a pair over valid/ready.
// Optional macro I2S_RX_LJ_MODE_EN adds an lj_mode input for the left-justified format.
// lj_mode is sampled in IDLE.
module i2s_slave_rx #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  sysclk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  bclk_in,
  input  logic                  lrclk_in,
  input  logic                  din,
`ifdef I2S_RX_LJ_MODE_EN
  input  logic                  lj_mode,
`endif
  output logic [DATA_WIDTH-1:0] sample_l,
  output logic [DATA_WIDTH-1:0] sample_r,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, WAIT_SYNC, RX_LEFT, RX_RIGHT} state_e;

  logic [SYNC_STAGES-1:0] bclk_sync_q, lr_sync_q, din_sync_q;
  logic                   bclk_prev_q, lr_prev_q;
  logic                   bclk_s, lr_s, din_s, tick, word_end;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  hold_l_q, hold_l_d;
  logic [DATA_WIDTH-1:0]  sample_l_q, sample_l_d, sample_r_q, sample_r_d;
  logic                   valid_q, valid_d, ovr_q, ovr_d, ferr_q, ferr_d;
  logic                   lj_q;

  logic [DATA_WIDTH-1:0]  bit_shift, closed_raw, closed_word, start_shift;
  logic [CNT_W-1:0]       bit_cnt, closed_cnt, start_cnt;

  assign bclk_s   = bclk_sync_q[SYNC_STAGES-1];
  assign lr_s     = lr_sync_q[SYNC_STAGES-1];
  assign din_s    = din_sync_q[SYNC_STAGES-1];
  assign tick     = bclk_s & ~bclk_prev_q;
  assign word_end = tick & (lr_s != lr_prev_q);

  // Synchronizer chains, bclk edge history and lrclk value at the previous tick
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      bclk_sync_q <= '0;
      lr_sync_q   <= '0;
      din_sync_q  <= '0;
      bclk_prev_q <= 1'b0;
      lr_prev_q   <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], bclk_in};
      lr_sync_q   <= {lr_sync_q[SYNC_STAGES-2:0], lrclk_in};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], din};
      bclk_prev_q <= bclk_s;
      if (tick) lr_prev_q <= lr_s;
    end
  end

`ifdef I2S_RX_LJ_MODE_EN
  // Format select is captured only while idle, so it cannot change mid-stream
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset)              lj_q <= 1'b0;
    else if (state_q == IDLE) lj_q <= lj_mode;
  end
`else
  assign lj_q = 1'b0;
`endif

  // Word datapath: bit insertion, the word closed at a word end, and the new-word seed
  always_comb begin
    bit_shift = shift_q;
    bit_cnt   = cnt_q;
    if (cnt_q < FULL) begin
      bit_shift = {shift_q[DATA_WIDTH-2:0], din_s};
      bit_cnt   = cnt_q + 1'b1;
    end
    if (lj_q) begin
      // Left-justified: the tick bit already belongs to the new word
      closed_raw  = shift_q;
      closed_cnt  = cnt_q;
      start_shift = {{(DATA_WIDTH-1){1'b0}}, din_s};
      start_cnt   = CNT_W'(1);
    end else begin
      // I2S: the tick bit is the last bit of the closing word
      closed_raw  = bit_shift;
      closed_cnt  = bit_cnt;
      start_shift = '0;
      start_cnt   = '0;
    end
    // Short words are MSB-aligned with zero LSBs
    closed_word = closed_raw << (FULL - closed_cnt);
  end

  // Next-state and output logic for the framing FSM and handshake
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    hold_l_d   = hold_l_q;
    sample_l_d = sample_l_q;
    sample_r_d = sample_r_q;
    valid_d    = valid_q;
    ovr_d      = 1'b0;
    ferr_d     = 1'b0;
    if (!enable) begin
      state_d  = IDLE;
      shift_d  = '0;
      cnt_d    = '0;
      hold_l_d = '0;
      valid_d  = 1'b0;
    end else begin
      if (valid_q && sample_ready) valid_d = 1'b0;
      case (state_q)
        IDLE: begin
          state_d = WAIT_SYNC;
          shift_d = '0;
          cnt_d   = '0;
        end
        WAIT_SYNC: begin
          shift_d = '0;
          cnt_d   = '0;
          if (word_end && lr_prev_q && !lr_s) begin
            state_d = RX_LEFT;
            shift_d = start_shift;
            cnt_d   = start_cnt;
          end
        end
        RX_LEFT, RX_RIGHT: begin
          if (word_end) begin
            shift_d = start_shift;
            cnt_d   = start_cnt;
            ferr_d  = (closed_cnt < FULL);
            if (state_q == RX_LEFT) begin
              hold_l_d = closed_word;
              state_d  = RX_RIGHT;
            end else begin
              state_d = RX_LEFT;
              if (valid_q && !sample_ready) begin
                ovr_d = 1'b1;
              end else begin
                sample_l_d = hold_l_q;
                sample_r_d = closed_word;
                valid_d    = 1'b1;
              end
            end
          end else if (tick) begin
            shift_d = bit_shift;
            cnt_d   = bit_cnt;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, datapath and output registers
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      hold_l_q   <= '0;
      sample_l_q <= '0;
      sample_r_q <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      hold_l_q   <= hold_l_d;
      sample_l_q <= sample_l_d;
      sample_r_q <= sample_r_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign sample_l     = sample_l_q;
  assign sample_r     = sample_r_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;
  assign frame_err    = ferr_q;

endmodule

// File: tb/tb_i2s_slave_rx.sv
// Scoreboard bench for i2s_slave_rx: directed I2S frames, expected pairs queued at issue,
// monitor pops and compares on every accepted pair. Build with I2S_RX_LJ_MODE_EN for the LJ test.
module tb_i2s_slave_rx;
  localparam int DW = 16;

  logic          sysclk = 1'b0;
  logic          reset, enable, bclk_in, lrclk_in, din, sample_ready;
`ifdef I2S_RX_LJ_MODE_EN
  logic          lj_mode;
`endif
  logic [DW-1:0] sample_l, sample_r;
  logic          sample_valid, overrun, frame_err;

  int checks = 0, passes = 0, ferr_cnt = 0, ovr_cnt = 0, pair_no = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pair;

  i2s_slave_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .sysclk(sysclk), .reset(reset), .enable(enable),
    .bclk_in(bclk_in), .lrclk_in(lrclk_in), .din(din),
`ifdef I2S_RX_LJ_MODE_EN
    .lj_mode(lj_mode),
`endif
    .sample_l(sample_l), .sample_r(sample_r), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .overrun(overrun), .frame_err(frame_err)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // One bit slot: 4 sysclk low, 4 sysclk high (bclk = sysclk/8); lrclk/din change at the fall
  task automatic slot(input logic lr, input logic d);
    bclk_in  = 1'b0;
    lrclk_in = lr;
    din      = d;
    repeat (4) @(negedge sysclk);
    bclk_in = 1'b1;
    repeat (4) @(negedge sysclk);
  endtask

  // Sends n-bit left then right word MSB first. I2S: lrclk leads data by one slot,
  // so the right word closes on the last slot of the call. LJ: lrclk aligned with data.
  task automatic send_pair(input logic [31:0] l, input logic [31:0] r, input int n, input bit lj);
    for (int t = 0; t < 2 * n; t++) begin
      logic d;
      logic lr;
      if (t < n) d = l[n-1-t];
      else       d = r[2*n-1-t];
      if (lj) lr = (t >= n);
      else    lr = ((t + 1) >= n) && ((t + 1) < 2 * n);
      slot(lr, d);
    end
  endtask

  task automatic set_ready(input logic v);
    @(posedge sysclk);
    #2 sample_ready = v;
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    exp_q.push_back({l, r});
  endtask

  // Monitor: counts status pulses and checks every accepted pair against the scoreboard
  always @(negedge sysclk) begin
    if (reset) begin
      if (frame_err) ferr_cnt++;
      if (overrun)   ovr_cnt++;
      if (sample_valid && sample_ready) begin
        pair_no++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_pair: got L=0x%0h R=0x%0h, required no pair", sample_l, sample_r);
        end else begin
          exp_pair = exp_q.pop_front();
          chk("pair_l", 32'(sample_l), 32'(exp_pair[31:16]));
          chk("pair_r", 32'(sample_r), 32'(exp_pair[15:0]));
          $display("pair %0d: L=0x%04h R=0x%04h (expected 0x%04h/0x%04h)",
                   pair_no, sample_l, sample_r, exp_pair[31:16], exp_pair[15:0]);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; enable = 1'b0; sample_ready = 1'b1;
    bclk_in = 1'b0; lrclk_in = 1'b0; din = 1'b0;
`ifdef I2S_RX_LJ_MODE_EN
    lj_mode = 1'b0;
`endif
    repeat (3) @(negedge sysclk);
    chk("reset_sample_l", 32'(sample_l), 0);
    chk("reset_sample_r", 32'(sample_r), 0);
    chk("reset_valid", 32'(sample_valid), 0);
    chk("reset_overrun", 32'(overrun), 0);
    chk("reset_frame_err", 32'(frame_err), 0);
    reset = 1'b1; enable = 1'b1;
    @(negedge sysclk);

    // Standard frames: sync pair is discarded, then A5C3/1234 with exact valid latency
    ferr_cnt = 0;
    send_pair(32'h0, 32'h0, 16, 1'b0);
    push(16'hA5C3, 16'h1234);
    fork
      send_pair(32'hA5C3, 32'h1234, 16, 1'b0);
      begin
        repeat (16 * 16 - 2) @(negedge sysclk);
        chk("valid_before_commit", 32'(sample_valid), 0);
        @(negedge sysclk);
        chk("valid_after_commit", 32'(sample_valid), 1);
      end
    join
    chk("std_frame_err", 32'(ferr_cnt), 0);

    // Short words: zero-padded LSBs and two frame errors
    ferr_cnt = 0;
    push(16'hABC0, 16'h1230);
    send_pair(32'hABC, 32'h123, 12, 1'b0);
    chk("short_frame_err", 32'(ferr_cnt), 2);

    // Long words: extra LSBs dropped, no frame error
    ferr_cnt = 0;
    push(16'hA5C3, 16'h1234);
    send_pair(32'hA5C3FF, 32'h1234EE, 24, 1'b0);
    chk("long_frame_err", 32'(ferr_cnt), 0);

    // Overrun: ready low across two pairs keeps the first, one overrun pulse
    set_ready(1'b0);
    ovr_cnt = 0;
    push(16'h1111, 16'h2222);
    send_pair(32'h1111, 32'h2222, 16, 1'b0);
    send_pair(32'h3333, 32'h4444, 16, 1'b0);
    chk("ovr_hold_l", 32'(sample_l), 32'h1111);
    chk("ovr_hold_r", 32'(sample_r), 32'h2222);
    chk("ovr_valid", 32'(sample_valid), 1);
    chk("ovr_count", 32'(ovr_cnt), 1);
    set_ready(1'b1);
    repeat (2) @(negedge sysclk);

    // Commit in the same cycle as acceptance: both pairs delivered, no overrun
    set_ready(1'b0);
    ovr_cnt = 0;
    push(16'h5A5A, 16'hA5A5);
    send_pair(32'h5A5A, 32'hA5A5, 16, 1'b0);
    push(16'h0F0F, 16'hF0F0);
    fork
      send_pair(32'h0F0F, 32'hF0F0, 16, 1'b0);
      begin
        repeat (16 * 16 - 3) @(negedge sysclk);
        @(posedge sysclk);
        #2 sample_ready = 1'b1;
      end
    join
    repeat (3) @(negedge sysclk);
    chk("same_cycle_overrun", 32'(ovr_cnt), 0);
    chk("same_cycle_delivered", 32'(exp_q.size()), 0);

    // Startup mid-frame: enable halfway through a right word, partial pair discarded
    enable = 1'b0;
    repeat (4) @(negedge sysclk);
    fork
      send_pair(32'hDEAD, 32'hBEEF, 16, 1'b0);
      begin
        repeat (24 * 8) @(negedge sysclk);
        enable = 1'b1;
      end
    join
    push(16'hC3C3, 16'h3C3C);
    send_pair(32'hC3C3, 32'h3C3C, 16, 1'b0);

    // Reset during bit 7 of a left word: immediate clear, then resync
    fork
      send_pair(32'h1357, 32'h2468, 16, 1'b0);
      begin
        repeat (7 * 8 + 2) @(negedge sysclk);
        reset = 1'b0;
        #1;
        chk("rst_mid_sample_l", 32'(sample_l), 0);
        chk("rst_mid_sample_r", 32'(sample_r), 0);
        chk("rst_mid_valid", 32'(sample_valid), 0);
        repeat (3) @(negedge sysclk);
        reset = 1'b1;
      end
    join
    push(16'h9ABC, 16'hDEF0);
    send_pair(32'h9ABC, 32'hDEF0, 16, 1'b0);

    // Enable dropped during bit 7 of a left word: valid cleared, data kept, resync
    set_ready(1'b0);
    send_pair(32'h5555, 32'h6666, 16, 1'b0);
    chk("en_pre_valid", 32'(sample_valid), 1);
    fork
      send_pair(32'h7777, 32'h8888, 16, 1'b0);
      begin
        repeat (7 * 8 + 2) @(negedge sysclk);
        enable = 1'b0;
        @(negedge sysclk);
        chk("en_mid_valid", 32'(sample_valid), 0);
        chk("en_mid_keep_l", 32'(sample_l), 32'h5555);
        chk("en_mid_keep_r", 32'(sample_r), 32'h6666);
        repeat (2) @(negedge sysclk);
        enable = 1'b1;
      end
    join
    set_ready(1'b1);
    push(16'h0123, 16'h4567);
    send_pair(32'h0123, 32'h4567, 16, 1'b0);

`ifdef I2S_RX_LJ_MODE_EN
    // Left-justified frames: sync pair, target pair, then one slot to close the right word
    enable = 1'b0;
    lj_mode = 1'b1;
    repeat (3) @(negedge sysclk);
    enable = 1'b1;
    send_pair(32'h0, 32'h0, 16, 1'b1);
    push(16'h8001, 16'h7FFE);
    send_pair(32'h8001, 32'h7FFE, 16, 1'b1);
    slot(1'b0, 1'b0);
`endif

    repeat (5) @(negedge sysclk);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
